// File: rtl/coin_sender_if.sv
// ---------------------------------------------------------------------------
// coin_sender_if
// Bundles every non-clock signal of coin_sender.
//   Key side    : req_half, req_one  (one-cycle insertion requests)
//   Vendor side : po_money_half, po_money_one (coin pulses out),
//                 pi_cola, pi_change (vend responses in)
//   Status      : credit, fifo_level, busy, ovf, err_timeout, err_vend,
//                 cola_cnt, change_cnt, dbg_state (current FSM state)
//
// Handshake semantics: there is no valid/ready pair on this block. Every
// request and every coin/vend signal is a single-cycle pulse, sampled on the
// rising clock edge; a level held for N cycles counts as N pulses. Requests
// that cannot be queued are dropped and reported on ovf.
// modport master : the coin_sender itself.
// modport slave  : whatever drives the requests and plays the vendor.
// ---------------------------------------------------------------------------
interface coin_sender_if;
   logic       req_half;
   logic       req_one;
   logic       pi_cola;
   logic       pi_change;
   logic       po_money_half;
   logic       po_money_one;
   logic [2:0] credit;
   logic [2:0] fifo_level;
   logic       busy;
   logic       ovf;
   logic       err_timeout;
   logic       err_vend;
   logic [7:0] cola_cnt;
   logic [7:0] change_cnt;
   logic [1:0] dbg_state;

   modport master (
      input  req_half, req_one, pi_cola, pi_change,
      output po_money_half, po_money_one, credit, fifo_level, busy, ovf,
             err_timeout, err_vend, cola_cnt, change_cnt, dbg_state
   );

   modport slave (
      output req_half, req_one, pi_cola, pi_change,
      input  po_money_half, po_money_one, credit, fifo_level, busy, ovf,
             err_timeout, err_vend, cola_cnt, change_cnt, dbg_state
   );
endinterface

// File: rtl/coin_sender.sv
// ---------------------------------------------------------------------------
// coin_sender
// Payment-side driver for the cola vending FSM. Queues half/one coin requests
// in a 4-entry FIFO (1 bit per entry: 0 = half, 1 = one) and replays them to
// the vendor as single-cycle coin pulses with enforced spacing. Keeps a
// mirror of the vendor's credit, checks the returned cola/change pulses and
// counts colas and change.
//
// Ports:
//   sys_clk : clock, rising edge
//   sys_rst : asynchronous active-high reset, clears all state
//   bus     : coin_sender_if.master (requests, vendor pulses, status)
// Parameters:
//   GAP     : idle cycles after each coin before the next pop (>= 1)
//   TIMEOUT : WAIT_VEND cycles without pi_cola before err_timeout (>= 2)
// dbg_state encoding: 0 IDLE, 1 SEND, 2 WAIT_VEND, 3 GAP.
// ---------------------------------------------------------------------------
module coin_sender #(
   parameter int GAP     = 4,
   parameter int TIMEOUT = 8
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   coin_sender_if.master bus
);

   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int TMO_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_WAIT = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   // ---------------- FIFO state ----------------
   logic [3:0] mem_q;
   logic [1:0] wr_ptr_q;
   logic [1:0] rd_ptr_q;
   logic [2:0] count_q;
   logic [2:0] count_d;
   logic       ovf_q;
   logic       ovf_d;

   // ---------------- FSM state ----------------
   state_t     state_q;
   logic       coin_q;        // coin being sent: 0 = half, 1 = one
   logic       exp_change_q;
   logic [2:0] credit_q;
   logic [GAP_W-1:0] gap_cnt_q;
   logic [TMO_W-1:0] tmo_cnt_q;
   logic       po_half_q;
   logic       po_one_q;
   logic       busy_q;
   logic       busy_d;
   logic       err_timeout_q;
   logic       err_vend_q;
   logic [7:0] cola_cnt_q;
   logic [7:0] change_cnt_q;

   // ---------------- push / pop decode ----------------
   logic [2:0] free_slots;
   logic [1:0] n_push;
   logic       first_bit;
   logic       pop;
   logic       head_bit;
   logic [2:0] sum;
   logic       gap_done;
   logic       tmo_done;
   logic       idle_next;

   always_comb begin
      // Space is judged on the registered count only; a pop in this cycle
      // does not make room for a push in the same cycle.
      free_slots = 3'd4 - count_q;
      pop        = (state_q == S_IDLE) && (count_q != 3'd0);
      head_bit   = mem_q[rd_ptr_q];
      n_push     = 2'd0;
      ovf_d      = 1'b0;
      // The first written bit is half unless only req_one is present.
      first_bit  = bus.req_one && !bus.req_half;
      if (bus.req_half && bus.req_one) begin
         if (free_slots >= 3'd2) begin
            n_push = 2'd2;
         end else if (free_slots == 3'd1) begin
            n_push = 2'd1;
            ovf_d  = 1'b1;
         end else begin
            ovf_d  = 1'b1;
         end
      end else if (bus.req_half || bus.req_one) begin
         if (free_slots != 3'd0) begin
            n_push = 2'd1;
         end else begin
            ovf_d  = 1'b1;
         end
      end
      count_d = count_q + 3'(n_push) - 3'(pop);

      sum       = credit_q + (coin_q ? 3'd2 : 3'd1);
      gap_done  = (gap_cnt_q == GAP_W'(GAP - 1));
      tmo_done  = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
      // FSM will sit in IDLE after this edge.
      idle_next = ((state_q == S_IDLE) && !pop) || ((state_q == S_GAP) && gap_done);
      busy_d    = !idle_next || (count_d != 3'd0);
   end

   // ---------------- FIFO storage ----------------
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         mem_q    <= 4'd0;
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
         ovf_q    <= 1'b0;
      end else begin
         if (n_push != 2'd0) mem_q[wr_ptr_q] <= first_bit;
         if (n_push == 2'd2) mem_q[wr_ptr_q + 2'd1] <= 1'b1;
         wr_ptr_q <= wr_ptr_q + n_push;
         if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q       <= S_IDLE;
         coin_q        <= 1'b0;
         exp_change_q  <= 1'b0;
         credit_q      <= 3'd0;
         gap_cnt_q     <= '0;
         tmo_cnt_q     <= '0;
         po_half_q     <= 1'b0;
         po_one_q      <= 1'b0;
         busy_q        <= 1'b0;
         err_timeout_q <= 1'b0;
         err_vend_q    <= 1'b0;
         cola_cnt_q    <= 8'd0;
         change_cnt_q  <= 8'd0;
      end else begin
         po_half_q     <= 1'b0;
         po_one_q      <= 1'b0;
         err_timeout_q <= 1'b0;
         err_vend_q    <= 1'b0;
         busy_q        <= busy_d;

         if (bus.pi_change) change_cnt_q <= change_cnt_q + 8'd1;
         // Any vend response outside WAIT_VEND is unsolicited.
         if ((state_q != S_WAIT) && (bus.pi_cola || bus.pi_change)) err_vend_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  // Pulse register is loaded here so the coin is on the wire
                  // for exactly the SEND cycle.
                  coin_q    <= head_bit;
                  po_one_q  <= head_bit;
                  po_half_q <= !head_bit;
                  state_q   <= S_SEND;
               end
            end
            S_SEND: begin
               if (sum >= 3'd5) begin
                  credit_q     <= sum - 3'd5;
                  exp_change_q <= (sum == 3'd6);
                  tmo_cnt_q    <= '0;
                  state_q      <= S_WAIT;
               end else begin
                  credit_q  <= sum;
                  gap_cnt_q <= '0;
                  state_q   <= S_GAP;
               end
            end
            S_WAIT: begin
               if (bus.pi_cola) begin
                  cola_cnt_q <= cola_cnt_q + 8'd1;
                  if (bus.pi_change != exp_change_q) err_vend_q <= 1'b1;
                  gap_cnt_q  <= '0;
                  state_q    <= S_GAP;
               end else begin
                  // Change without a cola is never a valid vend.
                  if (bus.pi_change) err_vend_q <= 1'b1;
                  if (tmo_done) begin
                     err_timeout_q <= 1'b1;
                     credit_q      <= 3'd0;
                     gap_cnt_q     <= '0;
                     state_q       <= S_GAP;
                  end else begin
                     tmo_cnt_q <= tmo_cnt_q + 1'b1;
                  end
               end
            end
            S_GAP: begin
               if (gap_done) begin
                  state_q <= S_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // ---------------- outputs ----------------
   assign bus.po_money_half = po_half_q;
   assign bus.po_money_one  = po_one_q;
   assign bus.credit        = credit_q;
   assign bus.fifo_level    = count_q;
   assign bus.busy          = busy_q;
   assign bus.ovf           = ovf_q;
   assign bus.err_timeout   = err_timeout_q;
   assign bus.err_vend      = err_vend_q;
   assign bus.cola_cnt      = cola_cnt_q;
   assign bus.change_cnt    = change_cnt_q;
   assign bus.dbg_state     = state_q;

endmodule
